rs5_wishbone_bridge: RTL and testbench

- Sits between the RS5 core's native memory interface and the two Wishbone classic master ports of processorci_top: instruction port core_*, data port data_mem_*.
- Turns each core step into one instruction fetch plus an optional data access. Both are issued concurrently.
- Holds the core in stall until all acks return, then presents the registered read data for exactly one cycle.
- Adds a per-step bus timeout with a sticky error flag.

---
 rtl/rs5_wishbone_bridge.sv | 138 +++++++++++++
 tb/tb_rs5_wishbone_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs5_wishbone_bridge.sv
// Bridges the RS5 native memory interface onto two Wishbone classic master ports.
// Each core step issues one fetch plus an optional data access, with a per-step timeout.
module rs5_wishbone_bridge #(
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] FETCH_ERR_INSTR = 32'h0000_0013,
    parameter logic [31:0] DATA_ERR_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_address_i,
    output logic [31:0] instruction_o,
    input  logic        mem_operation_enable_i,
    input  logic [3:0]  mem_write_enable_i,
    input  logic [31:0] mem_address_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stall_o,
    output logic        ibus_cyc_o,
    output logic        ibus_stb_o,
    output logic        ibus_we_o,
    output logic [3:0]  ibus_sel_o,
    output logic [31:0] ibus_adr_o,
    input  logic [31:0] ibus_dat_i,
    input  logic        ibus_ack_i,
    output logic        dbus_cyc_o,
    output logic        dbus_stb_o,
    output logic        dbus_we_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_adr_o,
    output logic [31:0] dbus_dat_o,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack_i,
    output logic        bus_error_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_next;
    logic        ibus_done, dbus_done;
    logic        ibus_hit, dbus_hit;
    logic        ibus_done_next, dbus_done_next;
    logic        expire;
    logic [31:0] timeout_count;

    assign ibus_we_o  = 1'b0;
    assign ibus_sel_o = 4'hF;
    assign ibus_stb_o = ibus_cyc_o;
    assign dbus_stb_o = dbus_cyc_o;
    assign stall_o    = (state != RESP);

    always_comb begin
        ibus_hit       = 1'b0;
        dbus_hit       = 1'b0;
        ibus_done_next = ibus_done;
        dbus_done_next = dbus_done;
        expire         = 1'b0;
        state_next     = state;
        case (state)
            IDLE: state_next = BUSY;
            BUSY: begin
                ibus_hit       = ibus_cyc_o & ibus_ack_i;
                dbus_hit       = dbus_cyc_o & dbus_ack_i;
                ibus_done_next = ibus_done | ibus_hit;
                dbus_done_next = dbus_done | dbus_hit;
                // An ack landing on the expiry cycle completes its port normally.
                expire = (TIMEOUT_CYCLES != 0) &&
                         (timeout_count == 32'(TIMEOUT_CYCLES - 1)) &&
                         !(ibus_done_next && dbus_done_next);
                if ((ibus_done_next && dbus_done_next) || expire)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ibus_cyc_o    <= 1'b0;
            ibus_adr_o    <= 32'h0;
            dbus_cyc_o    <= 1'b0;
            dbus_we_o     <= 1'b0;
            dbus_sel_o    <= 4'h0;
            dbus_adr_o    <= 32'h0;
            dbus_dat_o    <= 32'h0;
            ibus_done     <= 1'b0;
            dbus_done     <= 1'b0;
            timeout_count <= 32'h0;
            instruction_o <= FETCH_ERR_INSTR;
            mem_data_o    <= 32'h0;
            bus_error_o   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    ibus_adr_o    <= {instruction_address_i[31:2], 2'b00};
                    ibus_cyc_o    <= 1'b1;
                    dbus_cyc_o    <= mem_operation_enable_i;
                    if (mem_operation_enable_i) begin
                        dbus_adr_o <= {mem_address_i[31:2], 2'b00};
                        dbus_we_o  <= |mem_write_enable_i;
                    end
                    dbus_sel_o    <= (|mem_write_enable_i) ? mem_write_enable_i : 4'hF;
                    dbus_dat_o    <= mem_data_i;
                    ibus_done     <= 1'b0;
                    dbus_done     <= !mem_operation_enable_i;
                    timeout_count <= 32'h0;
                end
                BUSY: begin
                    timeout_count <= timeout_count + 32'd1;
                    ibus_done     <= ibus_done_next;
                    dbus_done     <= dbus_done_next;
                    if (ibus_hit) begin
                        instruction_o <= ibus_dat_i;
                        ibus_cyc_o    <= 1'b0;
                    end
                    if (dbus_hit) begin
                        if (!dbus_we_o)
                            mem_data_o <= dbus_dat_i;
                        dbus_cyc_o <= 1'b0;
                    end
                    if (expire) begin
                        ibus_cyc_o  <= 1'b0;
                        dbus_cyc_o  <= 1'b0;
                        bus_error_o <= 1'b1;
                        if (!ibus_done_next)
                            instruction_o <= FETCH_ERR_INSTR;
                        if (!dbus_done_next && !dbus_we_o)
                            mem_data_o <= DATA_ERR_WORD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rs5_wishbone_bridge.sv
// Directed bench for rs5_wishbone_bridge: per-step expectations are queued and a
// monitor checks them whenever the bridge releases stall.
module tb_rs5_wishbone_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction_address_i;
    logic [31:0] instruction_o;
    logic        mem_operation_enable_i;
    logic [3:0]  mem_write_enable_i;
    logic [31:0] mem_address_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stall_o;
    logic        ibus_cyc_o, ibus_stb_o, ibus_we_o;
    logic [3:0]  ibus_sel_o;
    logic [31:0] ibus_adr_o;
    logic [31:0] ibus_dat_i;
    logic        ibus_ack_i;
    logic        dbus_cyc_o, dbus_stb_o, dbus_we_o;
    logic [3:0]  dbus_sel_o;
    logic [31:0] dbus_adr_o;
    logic [31:0] dbus_dat_o;
    logic [31:0] dbus_dat_i;
    logic        dbus_ack_i;
    logic        bus_error_o;

    rs5_wishbone_bridge #(
        .TIMEOUT_CYCLES (8),
        .FETCH_ERR_INSTR(32'h0000_0013),
        .DATA_ERR_WORD  (32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instruction_address_i(instruction_address_i), .instruction_o(instruction_o),
        .mem_operation_enable_i(mem_operation_enable_i), .mem_write_enable_i(mem_write_enable_i),
        .mem_address_i(mem_address_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .stall_o(stall_o),
        .ibus_cyc_o(ibus_cyc_o), .ibus_stb_o(ibus_stb_o), .ibus_we_o(ibus_we_o),
        .ibus_sel_o(ibus_sel_o), .ibus_adr_o(ibus_adr_o), .ibus_dat_i(ibus_dat_i),
        .ibus_ack_i(ibus_ack_i),
        .dbus_cyc_o(dbus_cyc_o), .dbus_stb_o(dbus_stb_o), .dbus_we_o(dbus_we_o),
        .dbus_sel_o(dbus_sel_o), .dbus_adr_o(dbus_adr_o), .dbus_dat_o(dbus_dat_o),
        .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i),
        .bus_error_o(bus_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Snapshots taken during the most recent step.
    logic [31:0] snap_iadr, snap_dadr, snap_ddat;
    logic        snap_dwe, snap_icyc, snap_istb, snap_dstb;
    logic [3:0]  snap_dsel;
    logic        dcyc_seen;
    int          idrop, ddrop, lat;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && stall_o === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_instr", instruction_o, e.instr);
                check("resp_mdata", mem_data_o, e.mdata);
                check("resp_err", {31'd0, bus_error_o}, {31'd0, e.err});
            end
        end
    end

    // One core step. Ack delays count cycles with cyc high; -1 means never ack.
    task automatic step(input logic [31:0] iaddr, input logic op, input logic [3:0] wen,
                        input logic [31:0] maddr, input logic [31:0] wdata,
                        input int idly, input int ddly,
                        input logic [31:0] idat, input logic [31:0] ddat,
                        input logic [31:0] e_instr, input logic [31:0] e_mdata, input logic e_err);
        exp_t e;
        int ic, dc;
        instruction_address_i  = iaddr;
        mem_operation_enable_i = op;
        mem_write_enable_i     = wen;
        mem_address_i          = maddr;
        mem_data_i             = wdata;
        e.instr = e_instr; e.mdata = e_mdata; e.err = e_err;
        exp_q.push_back(e);
        ic = 0; dc = 0; lat = 1; idrop = 0; ddrop = 0; dcyc_seen = 1'b0;
        @(negedge clk);
        lat = 2;
        snap_iadr = ibus_adr_o; snap_icyc = ibus_cyc_o; snap_istb = ibus_stb_o;
        snap_dadr = dbus_adr_o; snap_ddat = dbus_dat_o; snap_dwe = dbus_we_o;
        snap_dsel = dbus_sel_o; snap_dstb = dbus_stb_o;
        while (stall_o && lat < 40) begin
            if (dbus_cyc_o) dcyc_seen = 1'b1;
            if (!ibus_cyc_o && idrop == 0) idrop = lat;
            if (!dbus_cyc_o && ddrop == 0) ddrop = lat;
            ibus_ack_i = ibus_cyc_o && idly >= 0 && ic == idly;
            ibus_dat_i = ibus_ack_i ? idat : 32'hDEAD_BEEF;
            dbus_ack_i = dbus_cyc_o && ddly >= 0 && dc == ddly;
            dbus_dat_i = dbus_ack_i ? ddat : 32'hDEAD_BEEF;
            if (ibus_cyc_o) ic++;
            if (dbus_cyc_o) dc++;
            @(negedge clk);
            lat++;
            ibus_ack_i = 1'b0;
            dbus_ack_i = 1'b0;
        end
        if (!ibus_cyc_o && idrop == 0) idrop = lat;
        if (!dbus_cyc_o && ddrop == 0) ddrop = lat;
        if (stall_o) begin
            check("stall_release_timeout", 32'd1, 32'd0);
        end else begin
            // Stray ack with junk data across the RESP and following IDLE edges.
            ibus_ack_i = 1'b1;
            ibus_dat_i = 32'hBAD0_0BAD;
            @(negedge clk);
            check("stall_one_cycle", {31'd0, stall_o}, 32'd1);
            check("stray_ack_no_capture", instruction_o, e_instr);
            check("stray_ack_no_cyc", {31'd0, ibus_cyc_o}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        instruction_address_i = 32'h0; mem_operation_enable_i = 1'b0;
        mem_write_enable_i = 4'h0; mem_address_i = 32'h0; mem_data_i = 32'h0;
        ibus_dat_i = 32'h0; ibus_ack_i = 1'b0; dbus_dat_i = 32'h0; dbus_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", {31'd0, stall_o}, 32'd1);
        check("rst_icyc", {30'd0, ibus_cyc_o, ibus_stb_o}, 32'd0);
        check("rst_dctl", {29'd0, dbus_cyc_o, dbus_stb_o, dbus_we_o}, 32'd0);
        check("rst_dsel", {28'd0, dbus_sel_o}, 32'd0);
        check("rst_iadr", ibus_adr_o, 32'd0);
        check("rst_dadr", dbus_adr_o, 32'd0);
        check("rst_ddat", dbus_dat_o, 32'd0);
        check("rst_instr", instruction_o, 32'h0000_0013);
        check("rst_mdata", mem_data_o, 32'd0);
        check("rst_err", {31'd0, bus_error_o}, 32'd0);
        check("ibus_const", {27'd0, ibus_we_o, ibus_sel_o}, 32'h0000_000F);
        rst_n = 1'b1;

        // Fetch only.
        step(32'h0000_1006, 1'b0, 4'h0, 32'h0, 32'h0, 0, -1, 32'h0010_0093, 32'h0,
             32'h0010_0093, 32'h0, 1'b0);
        check("fetch_adr", snap_iadr, 32'h0000_1004);
        check("fetch_cyc_stb", {30'd0, snap_icyc, snap_istb}, 32'd3);
        check("fetch_no_dcyc", {31'd0, dcyc_seen}, 32'd0);
        check("fetch_latency", lat, 32'd3);

        // Byte write, data ack four cycles late.
        step(32'h0000_1008, 1'b1, 4'b0100, 32'h0000_2002, 32'hAABB_CCDD, 0, 4,
             32'h0020_0113, 32'hFFFF_FFFF, 32'h0020_0113, 32'h0, 1'b0);
        check("wr_we", {31'd0, snap_dwe}, 32'd1);
        check("wr_stb", {31'd0, snap_dstb}, 32'd1);
        check("wr_sel", {28'd0, snap_dsel}, 32'h4);
        check("wr_adr", snap_dadr, 32'h0000_2000);
        check("wr_dat", snap_ddat, 32'hAABB_CCDD);
        check("wr_ibus_drop", idrop, 32'd3);
        check("wr_latency", lat, 32'd7);

        // Read with simultaneous acks.
        step(32'h0000_100C, 1'b1, 4'h0, 32'h0000_4005, 32'h0, 2, 2,
             32'h0030_0193, 32'h1234_5678, 32'h0030_0193, 32'h1234_5678, 1'b0);
        check("rd_we", {31'd0, snap_dwe}, 32'd0);
        check("rd_sel", {28'd0, snap_dsel}, 32'hF);
        check("rd_adr", snap_dadr, 32'h0000_4004);
        check("rd_drop_together", idrop, ddrop);
        check("rd_latency", lat, 32'd5);

        // Data timeout: eight BUSY cycles then abort.
        step(32'h0000_1010, 1'b1, 4'h0, 32'h0000_5000, 32'h0, 0, -1,
             32'h0040_0213, 32'h0, 32'h0040_0213, 32'h0, 1'b1);
        check("to_latency", lat, 32'd10);
        check("to_ddrop", ddrop, 32'd10);

        // Error flag stays set through later steps.
        step(32'h0000_1014, 1'b0, 4'h0, 32'h0, 32'h0, 1, -1,
             32'h0050_0293, 32'h0, 32'h0050_0293, 32'h0, 1'b1);
        check("sticky_latency", lat, 32'd4);

        // Fetch timeout returns the NOP.
        step(32'h0000_1018, 1'b0, 4'h0, 32'h0, 32'h0, -1, -1,
             32'h0, 32'h0, 32'h0000_0013, 32'h0, 1'b1);
        check("fto_latency", lat, 32'd10);

        // Reset while both ports are busy.
        ibus_ack_i = 1'b0;
        instruction_address_i = 32'h0000_1020; mem_operation_enable_i = 1'b1;
        mem_write_enable_i = 4'h0; mem_address_i = 32'h0000_6000;
        @(negedge clk);
        check("mid_busy_cyc", {30'd0, ibus_cyc_o, dbus_cyc_o}, 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cyc", {28'd0, ibus_cyc_o, ibus_stb_o, dbus_cyc_o, dbus_stb_o}, 32'd0);
        check("mid_rst_stall", {31'd0, stall_o}, 32'd1);
        check("mid_rst_err", {31'd0, bus_error_o}, 32'd0);
        rst_n = 1'b1;
        ibus_ack_i = 1'b1; ibus_dat_i = 32'hBAD1_BAD1;
        dbus_ack_i = 1'b1; dbus_dat_i = 32'hBAD2_BAD2;
        step(32'h0000_3008, 1'b0, 4'h0, 32'h0, 32'h0, 1, -1,
             32'h0060_0313, 32'h0, 32'h0060_0313, 32'h0, 1'b0);
        check("post_rst_adr", snap_iadr, 32'h0000_3008);
        check("post_rst_latency", lat, 32'd4);

        ibus_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
